// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: LED blink-burst sequencer (N ON/OFF pairs followed by a GAP, with done pulse and abort)
module led_seq_ctrl #(
  parameter int CNT_W = 25,
  parameter logic [CNT_W-1:0] ON_MAX = 25'd24,
  parameter logic [CNT_W-1:0] OFF_MAX = 25'd24,
  parameter logic [CNT_W-1:0] GAP_MAX = 25'd49
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] blink_num,
  output logic       led_out,
  output logic       busy,
  output logic       done
);
  typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;
  state_t state;
  logic [CNT_W-1:0] timer;
  logic [3:0] rem;
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state <= IDLE;
      timer <= '0;
      rem <= '0;
      led_out <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      timer <= timer + 1'b1;
      if (state != IDLE && stop) begin
        state <= IDLE;
        timer <= '0;
        rem <= '0;
        led_out <= 1'b0;
        busy <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            timer <= '0;
            if (start && !stop) begin
              if (blink_num != 4'd0) begin
                rem <= blink_num;
                state <= ON;
                led_out <= 1'b1;
                busy <= 1'b1;
              end else begin
                done <= 1'b1;
              end
            end
          end
          ON: if (timer == ON_MAX) begin
            state <= OFF;
            timer <= '0;
            led_out <= 1'b0;
          end
          OFF: if (timer == OFF_MAX) begin
            timer <= '0;
            rem <= rem - 1'b1;
            state <= (rem > 4'd1) ? ON : GAP;
            led_out <= rem > 4'd1;
          end
          default: if (timer == GAP_MAX) begin
            state <= IDLE;
            timer <= '0;
            rem <= '0;
            busy <= 1'b0;
            done <= 1'b1;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb_led_seq_ctrl: table-driven and directed-sequence checks of led_seq_ctrl with short phase lengths
module tb_led_seq_ctrl;
  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic [3:0] blink_num = 4'd0;
  logic led_out, busy, done;
  int checks = 0;
  int errors = 0;

  always #10 sys_clk = ~sys_clk;

  led_seq_ctrl #(.CNT_W(25), .ON_MAX(25'd4), .OFF_MAX(25'd2), .GAP_MAX(25'd3)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .stop(stop),
    .blink_num(blink_num), .led_out(led_out), .busy(busy), .done(done)
  );

  typedef struct {
    logic st;
    logic sp;
    logic [3:0] bn;
    logic led;
    logic bsy;
    logic dn;
  } vec_t;
  vec_t tbl[18];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge sys_clk);
    #1;
  endtask

  // One start pulse of n blinks; a start with a different blink_num is thrown in mid-burst and must be ignored
  task automatic burst(input logic [3:0] n, input int cycles, output int busy_n, output int led_n, output int rise_n, output int done_n);
    logic prev;
    busy_n = 0; led_n = 0; rise_n = 0; done_n = 0; prev = 1'b0;
    start = 1'b1;
    blink_num = n;
    for (int i = 0; i < cycles; i++) begin
      step();
      start = (i == 4);
      if (i == 4) blink_num = 4'd7;
      busy_n += int'(busy);
      led_n += int'(led_out);
      rise_n += int'(led_out && !prev);
      done_n += int'(done);
      prev = led_out;
      if (done) check("done_with_busy_low", int'(busy), 0);
    end
  endtask

  initial begin
    int b, l, r, d, k;
    tbl[0]  = '{1'b1, 1'b0, 4'd1, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};

    #5;
    check("reset_led", int'(led_out), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    #15 sys_rst = 1'b1;

    // single burst, empty burst, start+stop in IDLE
    for (int i = 0; i < 18; i++) begin
      start = tbl[i].st;
      stop = tbl[i].sp;
      blink_num = tbl[i].bn;
      step();
      check($sformatf("vec%0d_led", i), int'(led_out), int'(tbl[i].led));
      check($sformatf("vec%0d_busy", i), int'(busy), int'(tbl[i].bsy));
      check($sformatf("vec%0d_done", i), int'(done), int'(tbl[i].dn));
    end
    start = 1'b0; stop = 1'b0; blink_num = 4'd0;

    // three blinks: 3 x 5 lit cycles, busy 3*8+4 = 28 cycles, one done
    burst(4'd3, 35, b, l, r, d);
    check("multi_busy_cycles", b, 28);
    check("multi_led_cycles", l, 15);
    check("multi_led_pulses", r, 3);
    check("multi_done_pulses", d, 1);

    // abort in the second ON phase (edges 9..13 are ON2)
    start = 1'b1; blink_num = 4'd3;
    step();
    start = 1'b0;
    repeat (9) step();
    check("abort_pre_led", int'(led_out), 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("abort_led", int'(led_out), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    b = 0; d = 0;
    repeat (6) begin
      step();
      b += int'(busy);
      d += int'(done);
    end
    check("abort_idle_busy", b, 0);
    check("abort_idle_done", d, 0);
    burst(4'd1, 16, b, l, r, d);
    check("after_abort_busy", b, 12);
    check("after_abort_led", l, 5);
    check("after_abort_done", d, 1);

    // back-to-back: start held on the done cycle
    start = 1'b1; blink_num = 4'd1;
    step();
    start = 1'b0;
    k = 0;
    while (!done && k < 50) begin
      step();
      k++;
    end
    check("b2b_done_seen", int'(done), 1);
    start = 1'b1; blink_num = 4'd2;
    step();
    start = 1'b0;
    check("b2b_busy", int'(busy), 1);
    check("b2b_led", int'(led_out), 1);
    check("b2b_done_low", int'(done), 0);
    b = 1; k = 0;
    while (k < 50) begin
      step();
      k++;
      if (done) break;
      b += int'(busy);
    end
    check("b2b_second_done", int'(done), 1);
    check("b2b_busy_cycles", b, 20);

    // reset asserted between edges while in OFF
    start = 1'b1; blink_num = 4'd2;
    step();
    start = 1'b0;
    repeat (6) step();
    check("rst_pre_busy", int'(busy), 1);
    #5 sys_rst = 1'b0;
    #1;
    check("rst_async_busy", int'(busy), 0);
    check("rst_async_led", int'(led_out), 0);
    check("rst_async_done", int'(done), 0);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    b = 0; d = 0; l = 0;
    repeat (20) begin
      step();
      b += int'(busy);
      d += int'(done);
      l += int'(led_out);
    end
    check("rst_release_busy", b, 0);
    check("rst_release_done", d, 0);
    check("rst_release_led", l, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
